lif_array: RTL and testbench

- Parametrised multi-channel leaky integrate-and-fire neuron array; successor to the single 8-bit LIF neuron used at the top level.
- Adds configurable width, channel count, leak rate, runtime threshold, refractory period, reset mode (zero/subtract), enable gating and a population spike counter.
- Sits between the input-current bus and the output pins / spike readout logic.

---
 rtl/lif_array.sv | 141 ++++++++++++++
 tb/tb_lif_array.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lif_array.sv
// -----------------------------------------------------------------------------
// lif_array
//
// Array of N_CH independent leaky integrate-and-fire neurons sharing one
// threshold and one reset mode. Each enabled cycle a non-refractory channel
// leaks (state >> LEAK_SHIFT), adds its input current and saturates the result.
// When the saturated result reaches the threshold, the channel fires. It then
// either clears to zero or subtracts the threshold, and ignores its input for
// REFRACTORY cycles. A population counter accumulates every spike.
//
// Parameters:
//   N_CH        number of channels (>= 1)
//   WIDTH       bits per membrane state / input current
//   LEAK_SHIFT  leak amount per step is state >> LEAK_SHIFT
//   REFRACTORY  cycles a channel ignores input after firing (0 = none)
//   COUNT_W     width of the population spike counter (wraps)
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   en          1 = integrate this cycle, 0 = hold state (spikes forced low)
//   current     packed unsigned currents, channel i at [i*WIDTH +: WIDTH]
//   thr         shared unsigned firing threshold
//   reset_mode  0 = reset to zero after a spike, 1 = subtract threshold
//   state       packed registered membrane potentials
//   spike       registered one-cycle spike pulses
//   spike_any   registered OR of spike
//   spike_cnt   total spikes since reset, modulo 2^COUNT_W
// -----------------------------------------------------------------------------
module lif_array #(
    parameter int N_CH       = 4,
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRACTORY = 2,
    parameter int COUNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [N_CH*WIDTH-1:0]   current,
    input  logic [WIDTH-1:0]        thr,
    input  logic                    reset_mode,
    output logic [N_CH*WIDTH-1:0]   state,
    output logic [N_CH-1:0]         spike,
    output logic                    spike_any,
    output logic [COUNT_W-1:0]      spike_cnt
);

    // The counter must be at least one bit wide, even when there is no
    // refractory period.
    localparam int REF_W = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    logic [WIDTH-1:0]   state_reg [N_CH];
    logic [WIDTH-1:0]   state_next [N_CH];
    logic [REF_W-1:0]   ref_reg [N_CH];
    logic [REF_W-1:0]   ref_next [N_CH];
    logic [N_CH-1:0]    spike_reg;
    logic [N_CH-1:0]    spike_next;
    logic               spike_any_reg;
    logic [COUNT_W-1:0] cnt_reg;
    logic [COUNT_W-1:0] cnt_next;
    logic [COUNT_W-1:0] pop_count;

    // Per-channel datapath: these are the values that apply when en is high.
    // Enable gating and reset are handled in the register process.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] st;
            logic [WIDTH-1:0] cur;
            logic [WIDTH-1:0] leaked;
            logic [WIDTH:0]   sum;
            logic [WIDTH-1:0] sat;
            logic             refractory;
            logic             fire;

            assign st     = state_reg[gi];
            assign cur    = current[gi*WIDTH +: WIDTH];
            // st - (st >> s) can never go below zero, so only the add can overflow.
            assign leaked = st - (st >> LEAK_SHIFT);
            assign sum    = {1'b0, leaked} + {1'b0, cur};
            assign sat    = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

            assign refractory = (ref_reg[gi] != '0);
            assign fire       = !refractory && (sat >= thr);

            assign spike_next[gi] = fire;

            // sat >= thr whenever fire is set, so the subtraction cannot wrap.
            assign state_next[gi] = refractory ? st :
                                    fire       ? (reset_mode ? (sat - thr) : '0) :
                                                 sat;

            assign ref_next[gi]   = refractory ? (ref_reg[gi] - REF_W'(1)) :
                                    fire       ? REF_W'(REFRACTORY) :
                                                 '0;

            assign state[gi*WIDTH +: WIDTH] = state_reg[gi];
        end
    endgenerate

    // Population count of the spikes that are registered on this edge.
    always_comb begin
        pop_count = '0;
        for (int i = 0; i < N_CH; i++) begin
            pop_count = pop_count + COUNT_W'(spike_next[i]);
        end
    end

    assign cnt_next = cnt_reg + pop_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_reg[i] <= '0;
                ref_reg[i]   <= '0;
            end
            spike_reg     <= '0;
            spike_any_reg <= 1'b0;
            cnt_reg       <= '0;
        end else if (en) begin
            for (int i = 0; i < N_CH; i++) begin
                state_reg[i] <= state_next[i];
                ref_reg[i]   <= ref_next[i];
            end
            spike_reg     <= spike_next;
            spike_any_reg <= |spike_next;
            cnt_reg       <= cnt_next;
        end else begin
            // Hold state, refractory counters and count. Spikes are pulses,
            // so they drop low.
            spike_reg     <= '0;
            spike_any_reg <= 1'b0;
        end
    end

    assign spike     = spike_reg;
    assign spike_any = spike_any_reg;
    assign spike_cnt = cnt_reg;

endmodule

// File: tb/tb_lif_array.sv
// -----------------------------------------------------------------------------
// tb_lif_array
//
// This bench drives two lif_array instances from the same inputs.
//   dut_a: N_CH=2, WIDTH=8, LEAK_SHIFT=1, REFRACTORY=2, COUNT_W=16
//   dut_b: N_CH=2, WIDTH=8, LEAK_SHIFT=1, REFRACTORY=0, COUNT_W=4
// On every cycle, both instances are compared against an arithmetic neuron
// model. Several directed sequences also check hand-computed values.
// -----------------------------------------------------------------------------
module tb_lif_array;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] current;
    logic [7:0]  thr;
    logic        reset_mode;

    logic [15:0] state_a, state_b;
    logic [1:0]  spike_a, spike_b;
    logic        any_a, any_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lif_array #(.N_CH(2), .WIDTH(8), .LEAK_SHIFT(1), .REFRACTORY(2), .COUNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .en(en), .current(current), .thr(thr),
        .reset_mode(reset_mode), .state(state_a), .spike(spike_a),
        .spike_any(any_a), .spike_cnt(cnt_a)
    );

    lif_array #(.N_CH(2), .WIDTH(8), .LEAK_SHIFT(1), .REFRACTORY(0), .COUNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .en(en), .current(current), .thr(thr),
        .reset_mode(reset_mode), .state(state_b), .spike(spike_b),
        .spike_any(any_b), .spike_cnt(cnt_b)
    );

    // ---------------- reference model (index 0 = dut_a, 1 = dut_b) ----------
    int m_st  [2][2];
    int m_ref [2][2];
    int m_sp  [2][2];
    int m_cnt [2];
    int m_refr [2] = '{2, 0};
    int m_mod  [2] = '{65536, 16};

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_cnt[d] = 0;
                for (int c = 0; c < 2; c++) begin
                    m_st[d][c] = 0; m_ref[d][c] = 0; m_sp[d][c] = 0;
                end
            end else if (!en) begin
                for (int c = 0; c < 2; c++) m_sp[d][c] = 0;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (m_ref[d][c] > 0) begin
                        m_ref[d][c] = m_ref[d][c] - 1;
                        m_sp[d][c]  = 0;
                    end else begin
                        int s;
                        s = m_st[d][c] - m_st[d][c] / 2 + int'(current[c*8 +: 8]);
                        if (s > 255) s = 255;
                        if (s >= int'(thr)) begin
                            m_sp[d][c]  = 1;
                            m_ref[d][c] = m_refr[d];
                            m_st[d][c]  = reset_mode ? s - int'(thr) : 0;
                        end else begin
                            m_sp[d][c]  = 0;
                            m_st[d][c]  = s;
                        end
                    end
                    m_cnt[d] = (m_cnt[d] + m_sp[d][c]) % m_mod[d];
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int c = 0; c < 2; c++) begin
            check($sformatf("a_state%0d", c), 32'(state_a[c*8 +: 8]), 32'(m_st[0][c]));
            check($sformatf("b_state%0d", c), 32'(state_b[c*8 +: 8]), 32'(m_st[1][c]));
            check($sformatf("a_spike%0d", c), 32'(spike_a[c]), 32'(m_sp[0][c]));
            check($sformatf("b_spike%0d", c), 32'(spike_b[c]), 32'(m_sp[1][c]));
        end
        check("a_any", 32'(any_a), 32'((m_sp[0][0] | m_sp[0][1]) != 0));
        check("b_any", 32'(any_b), 32'((m_sp[1][0] | m_sp[1][1]) != 0));
        check("a_cnt", 32'(cnt_a), 32'(m_cnt[0]));
        check("b_cnt", 32'(cnt_b), 32'(m_cnt[1]));
    endtask

    // Apply one cycle of inputs, then update the model and compare after the edge.
    task automatic tick(input logic r, input logic e, input logic m,
                        input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] t);
        reset = r; en = e; reset_mode = m; current = {c1, c0}; thr = t;
        @(posedge clk);
        #1;
        model_step();
        check_model();
        $display("cyc r=%0b en=%0b m=%0b cur=%h thr=%h | A st=%h sp=%b cnt=%0d | B st=%h sp=%b cnt=%0d",
                 r, e, m, current, t, state_a, spike_a, cnt_a, state_b, spike_b, cnt_b);
    endtask

    // ---------------- directed vector table (checked on dut_a) --------------
    typedef struct {
        logic       rst;
        logic       en;
        logic       mode;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] th;
        logic [7:0] e_st0;
        logic [1:0] e_sp;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        reset = 1'b1; en = 1'b0; reset_mode = 1'b0; current = '0; thr = '0;

        // Integration and leak, reset-to-zero, refractory of 2.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 8'h00, 2'b00, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 8'h20, 2'b00, 16'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 8'h30, 2'b00, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 8'h38, 2'b00, 16'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 8'h00, 2'b01, 16'd1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 8'h00, 2'b00, 16'd1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 8'h00, 2'b00, 16'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 8'h20, 2'b00, 16'd1};
        // Subtract mode: 0x30, then 0x48 fires leaving 0x08.
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h30, 8'h00, 8'h40, 8'h00, 2'b00, 16'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h30, 8'h00, 8'h40, 8'h30, 2'b00, 16'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h30, 8'h00, 8'h40, 8'h08, 2'b01, 16'd1};
        // Reset while en=0 still clears.
        tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h30, 8'h00, 8'h40, 8'h00, 2'b00, 16'd0};

        @(negedge clk);
        tick(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].c0, tbl[i].c1, tbl[i].th);
            check($sformatf("tbl%0d_st0", i), 32'(state_a[7:0]), 32'(tbl[i].e_st0));
            check($sformatf("tbl%0d_sp", i), 32'(spike_a), 32'(tbl[i].e_sp));
            check($sformatf("tbl%0d_cnt", i), 32'(cnt_a), 32'(tbl[i].e_cnt));
        end

        // Saturation: load ch1 to 0xFF via subtract mode with thr=0, then thr=0xFF.
        tick(1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00);
        check("sat_load_st1", 32'(state_a[15:8]), 32'hFF);
        check("sat_load_sp", 32'(spike_a), 32'h3);
        tick(1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00);
        check("sat_refr_st1", 32'(state_a[15:8]), 32'hFF);
        check("sat_thr0_b_st1", 32'(state_b[15:8]), 32'hFF);
        tick(1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'hFF);
        check("sat_fire_sp1", 32'(spike_a[1]), 32'h1);
        check("sat_fire_st1", 32'(state_a[15:8]), 32'h00);

        // Population on dut_b: thr=0, 5 enabled cycles -> 10 spikes, then hold.
        tick(1'b1, 1'b1, 1'b0, 8'h11, 8'h22, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h11, 8'h22, 8'h00);
            check("pop_spike", 32'(spike_b), 32'h3);
            check("pop_any", 32'(any_b), 32'h1);
        end
        check("pop_cnt", 32'(cnt_b), 32'd10);
        tick(1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 8'h00);
        check("hold_spike", 32'(spike_b), 32'h0);
        check("hold_cnt", 32'(cnt_b), 32'd10);
        check("hold_st0", 32'(state_b[7:0]), 32'h00);

        // Counter wrap on dut_b: 17 single-channel spikes -> 1 modulo 16.
        tick(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF);
        for (int i = 0; i < 17; i++) tick(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF);
        check("wrap_cnt", 32'(cnt_b), 32'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic       r, e, m;
            logic [7:0] c0, c1, t;
            r  = ($urandom_range(0, 59) == 0);
            e  = ($urandom_range(0, 4) != 0);
            m  = 1'($urandom_range(0, 1));
            c0 = 8'($urandom_range(0, 255));
            c1 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 80));
            t  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            tick(r, e, m, c0, c1, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
